and_input_debounce: RTL

//   Two-channel input conditioner directly upstream of simple_and. Synchronises

---
 rtl/and_input_debounce.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/and_input_debounce.sv
// ---------------------------------------------------------------------------
// and_input_debounce
//
// Two-channel input conditioner that sits directly in front of simple_and.
// Each raw input is brought into the clk domain through a SYNC_STAGES-deep
// flip-flop chain. It is then debounced by its own four-state FSM, so a level
// only reaches the AND gate after DEBOUNCE_CYCLES consecutive agreeing synced
// samples. The two channels are fully independent and run in parallel. There
// is no arbitration between them.
//
// Parameters
//   SYNC_STAGES      synchroniser depth per channel (>= 2)
//   DEBOUNCE_CYCLES  agreeing synced samples needed to flip an output (>= 1)
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   rst          in   asynchronous, active-high reset
//   raw_a        in   unsynchronised raw input, channel A
//   raw_b        in   unsynchronised raw input, channel B
//   in_a         out  debounced level, channel A (to simple_and.in_a)
//   in_b         out  debounced level, channel B (to simple_and.in_b)
//   chg_a        out  one-cycle pulse in the cycle in_a takes a new value
//   chg_b        out  one-cycle pulse in the cycle in_b takes a new value
//   dbg_state_a  out  FSM state of channel A (0 STABLE_LOW, 1 PEND_HIGH,
//                     2 STABLE_HIGH, 3 PEND_LOW)
//   dbg_state_b  out  FSM state of channel B, same encoding
//
// All outputs come straight from flops. No path runs from raw_x to an
// output without passing through registers.
// ---------------------------------------------------------------------------
module and_input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       in_a,
    output logic       in_b,
    output logic       chg_a,
    output logic       chg_b,
    output logic [1:0] dbg_state_a,
    output logic [1:0] dbg_state_b
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             w_s;       // synced samples, bit 0 = A, bit 1 = B
    state_t                 r_state [2];
    logic [CNT_W-1:0]       r_cnt   [2];
    logic [1:0]             r_out;
    logic [1:0]             r_chg;

    // Synchroniser chains. Bit 0 samples the raw pin, and the MSB feeds the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], raw_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], raw_b};
        end
    end

    assign w_s = {r_sync_b[SYNC_STAGES-1], r_sync_a[SYNC_STAGES-1]};

    // Debounce FSMs, one per channel. r_cnt holds the number of agreeing
    // samples seen so far in a pending state. It is cleared on every flip and
    // every bounce, so it never counts past DEBOUNCE_CYCLES-1 and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= STABLE_LOW;
                r_cnt[i]   <= '0;
            end
            r_out <= '0;
            r_chg <= '0;
        end else begin
            // chg is a single-cycle pulse. A flip below overrides this default.
            r_chg <= '0;
            for (int i = 0; i < 2; i++) begin
                case (r_state[i])
                    STABLE_LOW: begin
                        if (w_s[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                r_state[i] <= STABLE_HIGH;
                                r_out[i]   <= 1'b1;
                                r_chg[i]   <= 1'b1;
                                r_cnt[i]   <= '0;
                            end else begin
                                r_state[i] <= PEND_HIGH;
                                r_cnt[i]   <= CNT_ONE;
                            end
                        end else begin
                            r_cnt[i] <= '0;
                        end
                    end
                    PEND_HIGH: begin
                        if (!w_s[i]) begin
                            // bounce: the rising candidate is rejected
                            r_state[i] <= STABLE_LOW;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= STABLE_HIGH;
                            r_out[i]   <= 1'b1;
                            r_chg[i]   <= 1'b1;
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!w_s[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                r_state[i] <= STABLE_LOW;
                                r_out[i]   <= 1'b0;
                                r_chg[i]   <= 1'b1;
                                r_cnt[i]   <= '0;
                            end else begin
                                r_state[i] <= PEND_LOW;
                                r_cnt[i]   <= CNT_ONE;
                            end
                        end else begin
                            r_cnt[i] <= '0;
                        end
                    end
                    PEND_LOW: begin
                        if (w_s[i]) begin
                            // bounce: the falling candidate is rejected
                            r_state[i] <= STABLE_HIGH;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i] <= STABLE_LOW;
                            r_out[i]   <= 1'b0;
                            r_chg[i]   <= 1'b1;
                            r_cnt[i]   <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= STABLE_LOW;
                        r_out[i]   <= 1'b0;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign in_a        = r_out[0];
    assign in_b        = r_out[1];
    assign chg_a       = r_chg[0];
    assign chg_b       = r_chg[1];
    assign dbg_state_a = r_state[0];
    assign dbg_state_b = r_state[1];

endmodule
